// File: rtl/shift_sub_divider.sv
// Sequential restoring (shift-and-subtract) unsigned divider, one quotient bit per clock.
// Optional early-out for a zero divisor is enabled by defining DIV_ZERO_CHECK_EN.
module shift_sub_divider #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_start,
   input  logic [DATA_WIDTH-1:0] i_dividend,
   input  logic [DATA_WIDTH-1:0] i_divisor,
   output logic [DATA_WIDTH-1:0] o_quotient,
   output logic [DATA_WIDTH-1:0] o_remainder,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_div_by_zero
);

   localparam int N  = DATA_WIDTH;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [N:0]      acc_q, acc_d;
   logic [N-1:0]    quo_q, quo_d;
   logic [N-1:0]    dvs_q, dvs_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic [N:0]      trial;
   logic [N:0]      shifted;
`ifdef DIV_ZERO_CHECK_EN
   logic            dbz_q, dbz_d;
`endif

   // Partial remainder shifted left with the next dividend bit, then trial-subtracted.
   assign shifted = {acc_q[N-1:0], quo_q[N-1]};
   assign trial   = shifted - {1'b0, dvs_q};

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
`ifdef DIV_ZERO_CHECK_EN
      dbz_d   = dbz_q;
`endif
      case (state_q)
         S_IDLE, S_DONE: begin
            busy_d = 1'b0;
            if (state_q == S_DONE)
               state_d = S_IDLE;
            if (i_start) begin
               state_d = S_CALC;
               dvs_d   = i_divisor;
               quo_d   = i_dividend;
               acc_d   = '0;
               cnt_d   = CW'(N - 1);
               busy_d  = 1'b1;
`ifdef DIV_ZERO_CHECK_EN
               dbz_d   = 1'b0;
               if (i_divisor == '0) begin
                  state_d = S_DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  dbz_d   = 1'b1;
                  quo_d   = '1;
                  acc_d   = {1'b0, i_dividend};
               end
`endif
            end
         end
         S_CALC: begin
            if (!trial[N]) begin
               acc_d = trial;
               quo_d = {quo_q[N-2:0], 1'b1};
            end else begin
               acc_d = shifted;
               quo_d = {quo_q[N-2:0], 1'b0};
            end
            if (cnt_q == '0) begin
               state_d = S_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef DIV_ZERO_CHECK_EN
         dbz_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef DIV_ZERO_CHECK_EN
         dbz_q   <= dbz_d;
`endif
      end
   end

   assign o_quotient  = quo_q;
   assign o_remainder = acc_q[N-1:0];
   assign o_busy      = busy_q;
   assign o_done      = done_q;
`ifdef DIV_ZERO_CHECK_EN
   assign o_div_by_zero = dbz_q;
`else
   assign o_div_by_zero = 1'b0;
`endif

endmodule
